// File: rtl/s2m_pkg.sv
// s2m_pkg: shared constants, types and helpers for the stream-to-memory
// width packer.
//   S2M_OUT_W    output beat width (bits)
//   S2M_EMPTY_W  width of the beat empty count
//   s2m_state_e  packet framing state (IDLE / IN_PKT)
//   s2m_beat_t   one output beat: data, sop, eop, empty
//   calc_empty   empty bytes of a beat whose last word sits in lane idx
package s2m_pkg;

  localparam int S2M_OUT_W   = 512;
  localparam int S2M_EMPTY_W = 6;

  typedef enum logic {
    S2M_IDLE   = 1'b0,
    S2M_IN_PKT = 1'b1
  } s2m_state_e;

  typedef struct packed {
    logic [S2M_OUT_W-1:0]   data;
    logic                   sop;
    logic                   eop;
    logic [S2M_EMPTY_W-1:0] empty;
  } s2m_beat_t;

  // Lanes above idx are unused, each worth bpw bytes, plus the empty
  // bytes of the last word itself.
  function automatic int unsigned calc_empty(int unsigned idx,
                                             int unsigned in_empty,
                                             int unsigned ratio = S2M_OUT_W / 64,
                                             int unsigned bpw   = 8);
    return (ratio - 1 - idx) * bpw + in_empty;
  endfunction

endpackage

// File: rtl/s2m_pack_stats.sv
// s2m_pack_stats: packet and beat counters on the packer output.
//   clk_i, rst_i    clock, synchronous active-high reset
//   beat_hs_i       output beat handshake this cycle
//   eop_i           handshaken beat carries eop
//   stat_pkts_o     eop beats handshaken (wraps at 2^32)
//   stat_beats_o    beats handshaken (wraps at 2^32)
module s2m_pack_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        beat_hs_i,
  input  logic        eop_i,
  output logic [31:0] stat_pkts_o,
  output logic [31:0] stat_beats_o
);

  logic [31:0] pkts_q, beats_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkts_q  <= '0;
      beats_q <= '0;
    end else if (beat_hs_i) begin
      beats_q <= beats_q + 32'd1;
      if (eop_i) pkts_q <= pkts_q + 32'd1;
    end
  end

  assign stat_pkts_o  = pkts_q;
  assign stat_beats_o = beats_q;

endmodule

// File: rtl/s2m_stream_width_packer.sv
// s2m_stream_width_packer: packs a narrow Avalon-ST packet stream into
// OUT_W-bit beats for the stream-to-memory DMA sink. Word 0 of a beat sits
// in bits [IN_W-1:0]; partial final beats flush on eop with an empty count.
//   clk_clk, reset_reset        clock, synchronous active-high reset
//   in_*                        narrow input stream (data/valid/ready/sop/eop/empty)
//   out_*                       wide output beat (data/valid/ready/sop/eop/empty)
//   err_sop_mid                 sticky: sop arrived inside an open packet
//   err_eop_orphan              sticky: word arrived outside a packet without sop
//   stat_pkts, stat_beats       output counters, present only when
//                               S2M_PACKER_STATS_EN is defined
module s2m_stream_width_packer
  import s2m_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = S2M_OUT_W
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sop,
  input  logic                         in_eop,
  input  logic [$clog2(IN_W/8)-1:0]    in_empty,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [$clog2(OUT_W/8)-1:0]   out_empty,
  output logic                         err_sop_mid,
  output logic                         err_eop_orphan
`ifdef S2M_PACKER_STATS_EN
  ,
  output logic [31:0]                  stat_pkts,
  output logic [31:0]                  stat_beats
`endif
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int IDX_W = $clog2(RATIO);
  localparam int EW    = $clog2(OUT_W / 8);

  s2m_state_e                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q;
  logic [RATIO-1:0][IN_W-1:0]  acc_q;
  logic                        bsop_q;   // sop flag of the beat being assembled
  s2m_beat_t                   beat_q, beat_d;
  logic                        out_valid_q;
  logic                        err_sop_mid_q, err_eop_orphan_q;

  logic                        sop_mid, flush, ready_int;
  logic                        acc_word, complete, eff_sop;
  logic [RATIO-1:0][IN_W-1:0]  full;
  int unsigned                 last_idx;

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= S2M_IDLE;
    else             state_q <= state_d;
  end

  // Next state: a flush closes the open packet so the held sop word
  // enters next cycle as a fresh packet from IDLE.
  always_comb begin
    state_d = state_q;
    if (flush)         state_d = S2M_IDLE;
    else if (acc_word) state_d = in_eop ? S2M_IDLE : S2M_IN_PKT;
  end

  // Outputs of the framing FSM: a sop arriving over a partial beat stalls
  // the input for the cycle in which that partial beat is flushed.
  always_comb begin
    sop_mid   = (state_q == S2M_IN_PKT) && in_valid && in_sop && (idx_q != '0);
    ready_int = !reset_reset && !sop_mid && (!out_valid_q || out_ready);
    flush     = !reset_reset &&  sop_mid && (!out_valid_q || out_ready);
  end

  assign in_ready = ready_int;
  assign acc_word = in_valid && ready_int;
  assign complete = acc_word && ((idx_q == IDX_W'(RATIO - 1)) || in_eop);
  // Words outside a packet are treated as starting one.
  assign eff_sop  = in_sop || (state_q == S2M_IDLE);

  // Beat image: filled lanes from acc, the incoming word in lane idx,
  // zeros above.
  always_comb begin
    full = '0;
    for (int l = 0; l < RATIO; l++) begin
      if (IDX_W'(l) < idx_q)                 full[l] = acc_q[l];
      else if (IDX_W'(l) == idx_q && !flush) full[l] = in_data;
    end
  end

  always_comb begin
    last_idx     = 32'(idx_q) - (flush ? 32'd1 : 32'd0);
    beat_d       = beat_q;
    beat_d.data  = S2M_OUT_W'(full);
    beat_d.sop   = flush ? bsop_q : ((idx_q == '0) ? eff_sop : bsop_q);
    beat_d.eop   = flush || in_eop;
    beat_d.empty = '0;
    if (flush)
      beat_d.empty = S2M_EMPTY_W'(calc_empty(last_idx, 0, RATIO, IN_W / 8));
    else if (in_eop)
      beat_d.empty = S2M_EMPTY_W'(calc_empty(last_idx, 32'(in_empty), RATIO, IN_W / 8));
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      idx_q            <= '0;
      bsop_q           <= 1'b0;
      beat_q           <= '0;
      out_valid_q      <= 1'b0;
      err_sop_mid_q    <= 1'b0;
      err_eop_orphan_q <= 1'b0;
    end else begin
      if (flush || complete) begin
        beat_q      <= beat_d;
        out_valid_q <= 1'b1;
        idx_q       <= '0;
      end else begin
        if (out_ready) out_valid_q <= 1'b0;
        if (acc_word) begin
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == '0) bsop_q <= eff_sop;
        end
      end
      if (flush || (acc_word && in_sop && state_q == S2M_IN_PKT)) err_sop_mid_q <= 1'b1;
      if (acc_word && !in_sop && state_q == S2M_IDLE)             err_eop_orphan_q <= 1'b1;
    end
  end

  // Lanes above idx are masked when the beat is built, so acc needs no reset.
  always_ff @(posedge clk_clk) begin
    if (acc_word && !complete) acc_q[idx_q] <= in_data;
  end

  assign out_data       = beat_q.data[OUT_W-1:0];
  assign out_valid      = out_valid_q;
  assign out_sop        = beat_q.sop;
  assign out_eop        = beat_q.eop;
  assign out_empty      = beat_q.empty[EW-1:0];
  assign err_sop_mid    = err_sop_mid_q;
  assign err_eop_orphan = err_eop_orphan_q;

`ifdef S2M_PACKER_STATS_EN
  s2m_pack_stats u_stats (
    .clk_i        (clk_clk),
    .rst_i        (reset_reset),
    .beat_hs_i    (out_valid_q && out_ready),
    .eop_i        (beat_q.eop),
    .stat_pkts_o  (stat_pkts),
    .stat_beats_o (stat_beats)
  );
`endif

endmodule
